// File: rtl/mem_transmitter.sv
// MEM-stage store path: formats sb/sh/sw into byte lanes and strobes, flags bad
// stores, and queues legal ones in an in-order buffer drained to data memory.
module mem_transmitter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [2:0]  st_func3,
    output logic        st_ready,
    output logic        st_fault,
    output logic [31:0] st_fault_addr,
    input  logic        ld_check_valid,
    input  logic [31:0] ld_check_addr,
    output logic        ld_hazard,
    output logic        mem_wvalid,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_wready,
    output logic        buf_empty
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg, count_next;
    logic             st_fault_reg;
    logic [31:0]      st_fault_addr_reg;

    logic [29:0] waddr_mem [DEPTH];
    logic [31:0] wdata_mem [DEPTH];
    logic [3:0]  wstrb_mem [DEPTH];

    logic        legal;
    logic [31:0] fmt_data;
    logic [3:0]  fmt_strb;
    logic        accept, push, pop;
    logic [DEPTH-1:0] hit;
    logic        unused_ld_bits;

    // Lane replication and strobe generation for the incoming request
    always_comb begin
        legal    = 1'b0;
        fmt_data = st_data;
        fmt_strb = 4'b0000;
        case (st_func3)
            3'b000: begin
                legal    = 1'b1;
                fmt_data = {4{st_data[7:0]}};
                fmt_strb = 4'b0001 << st_addr[1:0];
            end
            3'b001: begin
                legal    = ~st_addr[0];
                fmt_data = {2{st_data[15:0]}};
                fmt_strb = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                legal    = (st_addr[1:0] == 2'b00);
                fmt_data = st_data;
                fmt_strb = 4'b1111;
            end
            default: begin
                legal    = 1'b0;
                fmt_data = st_data;
                fmt_strb = 4'b0000;
            end
        endcase
    end

    assign st_ready   = (count_reg != FULL_COUNT);
    assign accept     = st_valid && st_ready;
    assign push       = accept && legal;
    assign mem_wvalid = (count_reg != '0);
    assign pop        = mem_wvalid && mem_wready;
    assign buf_empty  = (count_reg == '0);

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            count_reg         <= '0;
            st_fault_reg      <= 1'b0;
            st_fault_addr_reg <= '0;
        end else begin
            count_reg    <= count_next;
            st_fault_reg <= accept && !legal;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (accept && !legal)
                st_fault_addr_reg <= st_addr;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] offset;
            logic             occupied;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    waddr_mem[gi] <= '0;
                    wdata_mem[gi] <= '0;
                    wstrb_mem[gi] <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    waddr_mem[gi] <= st_addr[31:2];
                    wdata_mem[gi] <= fmt_data;
                    wstrb_mem[gi] <= fmt_strb;
                end
            end

            // Entry is live when its distance from the head is below the fill level
            assign offset   = PTR_W'(gi) - rd_ptr_reg;
            assign occupied = ({1'b0, offset} < count_reg);
            assign hit[gi]  = occupied && (waddr_mem[gi] == ld_check_addr[31:2]);
        end
    endgenerate

    assign ld_hazard      = ld_check_valid && (|hit);
    assign unused_ld_bits = ^ld_check_addr[1:0];

    assign mem_waddr     = {waddr_mem[rd_ptr_reg], 2'b00};
    assign mem_wdata     = wdata_mem[rd_ptr_reg];
    assign mem_wstrb     = wstrb_mem[rd_ptr_reg];
    assign st_fault      = st_fault_reg;
    assign st_fault_addr = st_fault_addr_reg;

endmodule

// File: tb/tb_mem_transmitter.sv
// Scoreboard bench for mem_transmitter: expected writes queued at stimulus time,
// popped and compared whenever the write handshake completes.
module tb_mem_transmitter;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_func3;
    logic        st_ready;
    logic        st_fault;
    logic [31:0] st_fault_addr;
    logic        ld_check_valid;
    logic [31:0] ld_check_addr;
    logic        ld_hazard;
    logic        mem_wvalid;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_wready;
    logic        buf_empty;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_writes = 0;

    mem_transmitter #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_func3(st_func3),
        .st_ready(st_ready), .st_fault(st_fault), .st_fault_addr(st_fault_addr),
        .ld_check_valid(ld_check_valid), .ld_check_addr(ld_check_addr), .ld_hazard(ld_hazard),
        .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_wready(mem_wready), .buf_empty(buf_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("ok   %-14s obs=%08h exp=%08h", tag, obs, exp);
        end else begin
            $display("FAIL %-14s obs=%08h exp=%08h", tag, obs, exp);
        end
    endtask

    // Handshake monitor: each completed write must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && mem_wvalid && mem_wready) begin
            if (exp_q.size() == 0) begin
                check("unexp_write", mem_waddr, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", mem_waddr, e.addr);
                check("wr_data", mem_wdata, e.data);
                check("wr_strb", {28'd0, mem_wstrb}, {28'd0, e.strb});
                n_writes++;
            end
        end
    end

    function automatic logic model_hazard(input logic [31:0] a);
        model_hazard = 1'b0;
        foreach (exp_q[i])
            if (exp_q[i].addr[31:2] == a[31:2]) model_hazard = 1'b1;
    endfunction

    logic [31:0] exp_fault_addr = 32'd0;

    // Called just after a rising edge; presents one request for one cycle
    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic model_ready, is_legal;
        wr_t  e;
        model_ready = (exp_q.size() != DEPTH);
        check("st_ready", {31'd0, st_ready}, {31'd0, model_ready});
        is_legal = (f3 == 3'b000) || (f3 == 3'b001 && !a[0]) || (f3 == 3'b010 && a[1:0] == 2'b00);
        e.addr = {a[31:2], 2'b00};
        case (f3)
            3'b000:  begin e.data = {4{d[7:0]}};  e.strb = 4'b0001 << a[1:0]; end
            3'b001:  begin e.data = {2{d[15:0]}}; e.strb = a[1] ? 4'b1100 : 4'b0011; end
            default: begin e.data = d;            e.strb = 4'b1111; end
        endcase
        st_valid = 1'b1; st_addr = a; st_data = d; st_func3 = f3;
        @(posedge clk); #1;
        st_valid = 1'b0;
        if (model_ready && is_legal) exp_q.push_back(e);
        if (model_ready && !is_legal) exp_fault_addr = a;
        check("st_fault", {31'd0, st_fault}, {31'd0, model_ready && !is_legal});
        check("st_fault_addr", st_fault_addr, exp_fault_addr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input int budget);
        int cyc;
        cyc = 0;
        mem_wready = 1'b1;
        while (exp_q.size() != 0 && cyc < budget) begin @(posedge clk); #1; cyc++; end
        check("drain_done", exp_q.size(), 0);
        check("buf_empty", {31'd0, buf_empty}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_func3 = '0;
        ld_check_valid = 1'b0; ld_check_addr = '0; mem_wready = 1'b0;
        #12;
        check("rst_wvalid", {31'd0, mem_wvalid}, 32'd0);
        check("rst_empty", {31'd0, buf_empty}, 32'd1);
        check("rst_ready", {31'd0, st_ready}, 32'd1);
        check("rst_fault", {31'd0, st_fault}, 32'd0);
        check("rst_faddr", st_fault_addr, 32'd0);
        check("rst_waddr", mem_waddr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        idle(1);

        // Lane formatting
        mem_wready = 1'b1;
        store(3'b000, 32'h0000_1003, 32'hAABB_CCDD);
        check("sb_wvalid", {31'd0, mem_wvalid}, 32'd1);
        store(3'b001, 32'h0000_2002, 32'h0000_1234);
        store(3'b000, 32'h0000_1001, 32'h0000_005A);
        store(3'b001, 32'h0000_2000, 32'hFFFF_BEEF);
        store(3'b010, 32'h0000_2004, 32'hCAFE_F00D);
        drain(20);

        // Faults, including back-to-back pulses
        store(3'b010, 32'h0000_3001, 32'h1111_1111);
        store(3'b001, 32'h0000_3005, 32'h2222_2222);
        store(3'b011, 32'h0000_3008, 32'h3333_3333);
        idle(1);
        check("fault_clear", {31'd0, st_fault}, 32'd0);
        check("fault_empty", {31'd0, buf_empty}, 32'd1);
        check("fault_hold", st_fault_addr, 32'h0000_3008);

        // Fill, reject when full, backpressure stability, ordered drain
        mem_wready = 1'b0;
        for (int i = 0; i < 4; i++) store(3'b010, 32'h10 + 32'(i*4), 32'hD000_0000 + 32'(i));
        check("full_ready", {31'd0, st_ready}, 32'd0);
        store(3'b010, 32'h0000_0020, 32'hDEAD_DEAD);
        for (int i = 0; i < 5; i++) begin
            check("bp_wvalid", {31'd0, mem_wvalid}, 32'd1);
            check("bp_waddr", mem_waddr, exp_q[0].addr);
            check("bp_wdata", mem_wdata, exp_q[0].data);
            check("bp_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_q[0].strb});
            idle(1);
        end
        begin
            int w0;
            w0 = n_writes;
            mem_wready = 1'b1;
            idle(4);
            check("drain_rate", n_writes - w0, 4);
        end
        drain(20);

        // Simultaneous push/pop with pointer wrap
        mem_wready = 1'b0;
        store(3'b010, 32'h0000_0100, 32'hA000_0000);
        store(3'b010, 32'h0000_0104, 32'hA000_0001);
        mem_wready = 1'b1;
        for (int i = 0; i < 6; i++) store(3'b010, 32'h108 + 32'(i*4), 32'hB000_0000 + 32'(i));
        mem_wready = 1'b0;
        check("pp_ready", {31'd0, st_ready}, 32'd1);
        store(3'b000, 32'h0000_0200, 32'h0000_0077);
        store(3'b000, 32'h0000_0205, 32'h0000_0088);
        check("pp_full", {31'd0, st_ready}, 32'd0);
        drain(20);

        // Hazard check
        mem_wready = 1'b0;
        store(3'b000, 32'h0000_4001, 32'h0000_0042);
        ld_check_valid = 1'b1; ld_check_addr = 32'h0000_4003; #1;
        check("haz_same", {31'd0, ld_hazard}, {31'd0, model_hazard(ld_check_addr)});
        ld_check_addr = 32'h0000_4004; #1;
        check("haz_other", {31'd0, ld_hazard}, {31'd0, model_hazard(ld_check_addr)});
        ld_check_valid = 1'b0; ld_check_addr = 32'h0000_4000; #1;
        check("haz_novalid", {31'd0, ld_hazard}, 32'd0);

        // Asynchronous reset with pending stores
        store(3'b010, 32'h0000_5000, 32'h5555_0000);
        store(3'b010, 32'h0000_5004, 32'h5555_0001);
        #2; rst_n = 1'b0; #1;
        check("arst_wvalid", {31'd0, mem_wvalid}, 32'd0);
        check("arst_empty", {31'd0, buf_empty}, 32'd1);
        exp_q.delete();
        @(posedge clk); #1; rst_n = 1'b1;
        mem_wready = 1'b1;
        begin
            int w0;
            w0 = n_writes;
            idle(5);
            check("arst_nowr", n_writes - w0, 0);
        end
        check("arst_final", {31'd0, buf_empty}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
